// File: rtl/pipeline_pkg.sv
// Shared encodings for the RV32I pipeline stages.
package pipeline_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned ALU_OPW = 3;
  localparam int unsigned FWD_W   = 2;
  localparam int unsigned RSRC_W  = 2;

  typedef enum logic [ALU_OPW-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef enum logic [FWD_W-1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [RSRC_W-1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  // Control fields carried through the EX/MEM register.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [RSRC_W-1:0] result_src;
    logic              reg_write;
    logic              mem_write;
    logic              mem_read;
  } ex_mem_ctrl_t;

endpackage

// File: rtl/alu.sv
// Integer ALU for the execute stage: add/sub/and/or/slt, zero flag.
module alu
  import pipeline_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [ALU_OPW-1:0] AluControl,
  output logic [WIDTH-1:0]   result,
  output logic               zero
);

  // Operation select; unassigned codes yield zero.
  always_comb begin
    result = '0;
    case (AluControl)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = WIDTH'($signed(a) < $signed(b));
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/iexecute.sv
// Execute stage: operand forwarding, ALU, branch resolution, EX/MEM register.
module iexecute
  import pipeline_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    PCE,
  input  logic [WIDTH-1:0]    PCPlus4E,
  input  logic [WIDTH-1:0]    RD1E,
  input  logic [WIDTH-1:0]    RD2E,
  input  logic [WIDTH-1:0]    ImmExtE,
  input  logic [REG_AW-1:0]   RdE,
  input  logic [ALU_OPW-1:0]  AluControlE,
  input  logic [RSRC_W-1:0]   ResultSrcE,
  input  logic                RegWriteE,
  input  logic                MemWriteE,
  input  logic                MemReadE,
  input  logic                JumpE,
  input  logic                BranchE,
  input  logic                ALUSrcE,
  input  logic [FWD_W-1:0]    ForwardAE,
  input  logic [FWD_W-1:0]    ForwardBE,
  input  logic [WIDTH-1:0]    ResultW,
  output logic [WIDTH-1:0]    PCTargetE,
  output logic                PCSrcE,
  output logic [WIDTH-1:0]    ALUResultM,
  output logic [WIDTH-1:0]    WriteDataM,
  output logic [REG_AW-1:0]   RdM,
  output logic [WIDTH-1:0]    PCPlus4M,
  output logic [RSRC_W-1:0]   ResultSrcM,
  output logic                RegWriteM,
  output logic                MemWriteM,
  output logic                MemReadM
);

  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] WriteDataE;
  logic [WIDTH-1:0] SrcBE;
  logic [WIDTH-1:0] ALUResultE;
  logic             ZeroE;
  ex_mem_ctrl_t     ctrl_q;

  // Operand A forward select; code 11 falls back to the register value.
  always_comb begin
    SrcAE = RD1E;
    case (ForwardAE)
      FWD_WB:  SrcAE = ResultW;
      FWD_MEM: SrcAE = ALUResultM;
      default: SrcAE = RD1E;
    endcase
  end

  // Operand B / store-data forward select; code 11 falls back to the register value.
  always_comb begin
    WriteDataE = RD2E;
    case (ForwardBE)
      FWD_WB:  WriteDataE = ResultW;
      FWD_MEM: WriteDataE = ALUResultM;
      default: WriteDataE = RD2E;
    endcase
  end

  assign SrcBE = ALUSrcE ? ImmExtE : WriteDataE;

  alu #(.WIDTH(WIDTH)) u_alu (
    .a          (SrcAE),
    .b          (SrcBE),
    .AluControl (AluControlE),
    .result     (ALUResultE),
    .zero       (ZeroE)
  );

  assign PCTargetE = PCE + ImmExtE;
  assign PCSrcE    = JumpE | (BranchE & ZeroE);

  // EX/MEM pipeline register; no stall or flush, reset clears in-flight state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      ctrl_q     <= '0;
    end else begin
      ALUResultM <= ALUResultE;
      WriteDataM <= WriteDataE;
      PCPlus4M   <= PCPlus4E;
      ctrl_q     <= '{rd:         RdE,
                      result_src: ResultSrcE,
                      reg_write:  RegWriteE,
                      mem_write:  MemWriteE,
                      mem_read:   MemReadE};
    end
  end

  assign RdM        = ctrl_q.rd;
  assign ResultSrcM = ctrl_q.result_src;
  assign RegWriteM  = ctrl_q.reg_write;
  assign MemWriteM  = ctrl_q.mem_write;
  assign MemReadM   = ctrl_q.mem_read;

endmodule

// File: tb/tb_iexecute.sv
// Self-checking bench for the execute stage against a behavioural model.
module tb_iexecute;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCE, PCPlus4E, RD1E, RD2E, ImmExtE, ResultW;
  logic [4:0]  RdE;
  logic [2:0]  AluControlE;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
  logic        RegWriteE, MemWriteE, MemReadE, JumpE, BranchE, ALUSrcE;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic        PCSrcE, RegWriteM, MemWriteM, MemReadM;
  logic [4:0]  RdM;
  logic [1:0]  ResultSrcM;

  int unsigned total_cnt = 0;
  int unsigned pass_cnt  = 0;

  // Model of the stage's visible state after the most recent capture.
  logic [31:0] m_alu = '0, m_wd = '0, m_pc4 = '0;
  logic [4:0]  m_rd = '0;
  logic [1:0]  m_rs = '0;
  logic        m_rw = 1'b0, m_mw = 1'b0, m_mr = 1'b0;

  iexecute #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .PCE(PCE), .PCPlus4E(PCPlus4E), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .RdE(RdE), .AluControlE(AluControlE), .ResultSrcE(ResultSrcE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemReadE(MemReadE), .JumpE(JumpE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .PCTargetE(PCTargetE), .PCSrcE(PCSrcE), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M), .ResultSrcM(ResultSrcM),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemReadM(MemReadM)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] regv);
    if (sel == 2'b01) return ResultW;
    if (sel == 2'b10) return m_alu;
    return regv;
  endfunction

  function automatic logic [31:0] exp_alu_now();
    logic [31:0] a, bd;
    a  = fwd(ForwardAE, RD1E);
    bd = fwd(ForwardBE, RD2E);
    return alu_ref(a, ALUSrcE ? ImmExtE : bd, AluControlE);
  endfunction

  // Model capture: one-cycle delay of the spec-defined EX results, cleared by reset.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_alu <= '0; m_wd <= '0; m_pc4 <= '0; m_rd <= '0; m_rs <= '0;
      m_rw <= 1'b0; m_mw <= 1'b0; m_mr <= 1'b0;
    end else begin
      m_alu <= exp_alu_now();
      m_wd  <= fwd(ForwardBE, RD2E);
      m_pc4 <= PCPlus4E;
      m_rd  <= RdE;
      m_rs  <= ResultSrcE;
      m_rw  <= RegWriteE;
      m_mw  <= MemWriteE;
      m_mr  <= MemReadE;
    end
  end

  // Compare process on the falling edge, away from captures and input changes.
  always @(negedge clk) begin
    check("ALUResultM", ALUResultM, m_alu);
    check("WriteDataM", WriteDataM, m_wd);
    check("PCPlus4M", PCPlus4M, m_pc4);
    check("RdM", 32'(RdM), 32'(m_rd));
    check("ResultSrcM", 32'(ResultSrcM), 32'(m_rs));
    check("RegWriteM", 32'(RegWriteM), 32'(m_rw));
    check("MemWriteM", 32'(MemWriteM), 32'(m_mw));
    check("MemReadM", 32'(MemReadM), 32'(m_mr));
    check("PCTargetE", PCTargetE, PCE + ImmExtE);
    check("PCSrcE", 32'(PCSrcE),
          32'(JumpE | (BranchE & (exp_alu_now() == 32'd0))));
  end

  task automatic clear_inputs();
    PCE = '0; PCPlus4E = '0; RD1E = '0; RD2E = '0; ImmExtE = '0; ResultW = '0;
    RdE = '0; AluControlE = '0; ResultSrcE = '0; ForwardAE = '0; ForwardBE = '0;
    RegWriteE = 0; MemWriteE = 0; MemReadE = 0; JumpE = 0; BranchE = 0; ALUSrcE = 0;
  endtask

  task automatic rand_inputs();
    PCE = $urandom; PCPlus4E = PCE + 32'd4; RD1E = $urandom;
    RD2E = ($urandom_range(0, 3) == 0) ? RD1E : $urandom;
    ImmExtE = $urandom; ResultW = $urandom; RdE = 5'($urandom);
    AluControlE = 3'($urandom_range(0, 7)); ResultSrcE = 2'($urandom);
    ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
    RegWriteE = 1'($urandom); MemWriteE = 1'($urandom); MemReadE = 1'($urandom);
    JumpE = ($urandom_range(0, 5) == 0); BranchE = 1'($urandom); ALUSrcE = 1'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    rand_inputs();
    // Reset held with activity on the inputs and clock.
    repeat (3) begin
      step();
      rand_inputs();
    end
    #1;
    check("rst_ALUResultM", ALUResultM, 32'd0);
    check("rst_RegWriteM", 32'(RegWriteM), 32'd0);
    check("rst_MemWriteM", 32'(MemWriteM), 32'd0);

    // add 5+3 -> rd 7
    step();
    reset = 1'b1;
    clear_inputs();
    RD1E = 32'd5; RD2E = 32'd3; RdE = 5'd7; RegWriteE = 1'b1;
    step();
    check("add_ALUResultM", ALUResultM, 32'd8);
    check("add_RdM", 32'(RdM), 32'd7);
    check("add_RegWriteM", 32'(RegWriteM), 32'd1);

    // sub 3-5 wraps
    clear_inputs();
    RD1E = 32'd3; RD2E = 32'd5; AluControlE = 3'b001;
    step();
    check("sub_ALUResultM", ALUResultM, 32'hFFFF_FFFE);

    // slt -1 < 1 signed
    clear_inputs();
    RD1E = 32'hFFFF_FFFF; RD2E = 32'd1; AluControlE = 3'b101;
    step();
    check("slt_ALUResultM", ALUResultM, 32'd1);

    // Forward previous ALU result into A
    clear_inputs();
    RD1E = 32'd5; RD2E = 32'd3;
    step();
    clear_inputs();
    ForwardAE = 2'b10; ImmExtE = 32'd4; ALUSrcE = 1'b1;
    step();
    check("fwdA_ALUResultM", ALUResultM, 32'd12);

    // Store data forwarded from writeback
    clear_inputs();
    ForwardBE = 2'b01; ResultW = 32'h55; MemWriteE = 1'b1; ALUSrcE = 1'b1;
    step();
    check("fwdB_WriteDataM", WriteDataM, 32'h55);
    check("sw_MemWriteM", 32'(MemWriteM), 32'd1);

    // Reset between edges drops state at once; MEM forward reads 0
    reset = 1'b0;
    clear_inputs();
    ForwardAE = 2'b10; ALUSrcE = 1'b1; BranchE = 1'b1;
    #1;
    check("midrst_MemWriteM", 32'(MemWriteM), 32'd0);
    check("midrst_ALUResultM", ALUResultM, 32'd0);
    check("midrst_PCSrcE", 32'(PCSrcE), 32'd1);
    step();
    reset = 1'b1;

    // beq taken / not taken / jal
    clear_inputs();
    RD1E = 32'd9; RD2E = 32'd9; AluControlE = 3'b001; BranchE = 1'b1;
    PCE = 32'h100; ImmExtE = 32'hFFFF_FFF0;
    #1;
    check("beq_PCSrcE", 32'(PCSrcE), 32'd1);
    check("beq_PCTargetE", PCTargetE, 32'hF0);
    RD2E = 32'd8;
    #1;
    check("bne_PCSrcE", 32'(PCSrcE), 32'd0);
    JumpE = 1'b1;
    #1;
    check("jal_PCSrcE", 32'(PCSrcE), 32'd1);

    // Load, then bubble
    step();
    clear_inputs();
    MemReadE = 1'b1; RegWriteE = 1'b1; ResultSrcE = 2'b01; RdE = 5'd3;
    step();
    check("ld_MemReadM", 32'(MemReadM), 32'd1);
    clear_inputs();
    step();
    check("bub_MemReadM", 32'(MemReadM), 32'd0);
    check("bub_RegWriteM", 32'(RegWriteM), 32'd0);
    check("bub_MemWriteM", 32'(MemWriteM), 32'd0);

    // Randomized traffic with occasional reset pulses
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      reset = ($urandom_range(0, 29) != 0);
      step();
    end
    reset = 1'b1;
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
